// File: rtl/cdc_toggle_rx.sv
// Receive side of the two-phase toggle CDC handshake: synchronizes req_tgl, captures data_in,
// presents it on valid/ready and returns ack_tgl. Optional: CDC_TOGGLE_RX_EARLY_ACK_EN (ack on capture).
module cdc_toggle_rx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             myClock,
  input  logic             myNewReset,
  input  logic             req_tgl,
  input  logic [WIDTH-1:0] data_in,
  output logic             ack_tgl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [0:0]             state_q, state_d;
  logic                   req_seen_q, req_seen_d;
  logic                   ack_q, ack_d;
  logic [WIDTH-1:0]       data_q, data_d;
  logic                   req_s, pending, capture;

  // Pure shift chain: nothing may sit between synchronizer flops.
  assign sync_d  = {sync_q[SYNC_STAGES-2:0], req_tgl};
  assign req_s   = sync_q[SYNC_STAGES-1];
  assign pending = req_s ^ req_seen_q;

  always_comb begin
    state_d    = state_q;
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    data_d     = data_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending) begin
          capture = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_ready) begin
`ifdef CDC_TOGGLE_RX_EARLY_ACK_EN
          // A request held during FULL is taken on the consume edge itself.
          if (pending) capture = 1'b1;
          else         state_d = IDLE;
`else
          state_d = IDLE;
          ack_d   = ~ack_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) begin
      data_d     = data_in;
      req_seen_d = req_s;
`ifdef CDC_TOGGLE_RX_EARLY_ACK_EN
      ack_d      = ~ack_q;
`endif
    end
  end

  always_ff @(posedge myClock or posedge myNewReset) begin
    if (myNewReset) begin
      sync_q     <= '0;
      state_q    <= IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      data_q     <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      data_q     <= data_d;
    end
  end

  assign ack_tgl   = ack_q;
  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;

endmodule
